serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial, multi-cycle adder built around one half-adder pair and a carry flip-flop. It accepts two WIDTH-bit operands on a start handshake, then adds them LSB-first at one bit per clock. It presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential stage that follows the combinational half adder in the basic-arithmetic library and consumes its sum/carry behaviour bit by bit.

## Interface
- WIDTH, 8, operand and sum width in bits (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request to begin an addition; sampled only when ready=1
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- ready  output  1  block can accept start (high in IDLE and DONE)
- sum  output  WIDTH  registered result, valid from done pulse until next done
- carry  output  1  registered carry-out of MSB, same validity as sum
- done  output  1  one-cycle pulse: sum/carry just updated

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: ready=1, sum=0, carry=0, done=0. Internal shift registers, carry flop and bit counter are cleared.
- IDLE, start=1: capture A and B into shift registers, clear carry flop, clear bit counter, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - s = a0 ^ b0 ^ c
  - c' = (a0 & b0) | (c & (a0 ^ b0)), i.e. two cascaded half adders plus OR.
  - s shifts into the result register from the MSB side; operand registers shift right.
  - The counter increments. When counter == WIDTH-1, go to DONE.
- RUN→DONE edge: copy the result register to sum and the carry flop to carry.
- DONE: done=1 and ready=1 for exactly one cycle.
  - start=1 in DONE: accepted exactly as in IDLE, next state RUN.
  - Otherwise next state IDLE.
- start while in RUN (ready=0) is ignored. No queuing, and A/B changes have no effect.
- sum/carry hold their last values in IDLE and RUN. They change only on the RUN→DONE edge or on reset.
- Arithmetic: the result is modulo 2^WIDTH; carry is bit WIDTH of A+B. There is no overflow flag.
- rst=1 in any state, including mid-RUN, forces reset values on that edge. Any partial result is discarded and no done is issued.

## Timing
- Start accepted at edge k, so RUN occupies cycles k+1 … k+WIDTH.
- DONE state (done=1, new sum/carry visible) is cycle k+WIDTH+1.
- Latency is WIDTH+1 clocks from the accepting edge to done.
- Back-to-back throughput: one result per WIDTH+1 cycles, using start in DONE.
- WIDTH=1: RUN lasts one cycle; done appears 2 cycles after start.
- ready is combinational from state (IDLE or DONE). All other outputs are registered.

## Configuration
- SERIAL_ADDER_SUB_EN defined: adds port `sub  input  1`, captured with the operands on an accepted start.
  - sub=1: the B shift register loads ~B and the carry flop initialises to 1, giving sum = A−B mod 2^WIDTH.
  - carry=1 means no borrow (A≥B unsigned).
  - sub=0: behaves as plain addition.
- SERIAL_ADDER_SUB_EN undefined: no sub port; the carry flop always initialises to 0; addition only.

## Test plan
- Reset then idle, WIDTH=4: after rst, ready=1, sum=0, carry=0, done=0. These hold for 10 cycles with start=0.
- WIDTH=4, A=3, B=5, start for 1 cycle: done exactly 5 cycles later with sum=8, carry=0. sum holds 8 afterwards.
- WIDTH=4, wrap-around cases, each checked for done timing and result:
  - A=15, B=1: sum=0, carry=1.
  - A=15, B=15: sum=14, carry=1.
  - A=0, B=0: sum=0, carry=0.
- WIDTH=4, busy and reset handling:
  - start A=2, B=2, then pulse start with A=7, B=7 during RUN: single done, sum=4, carry=0.
  - Assert start again in the DONE cycle with A=1, B=1: second done 5 cycles later with sum=2.
- WIDTH=4, reset mid-operation: start A=9, B=9, assert rst on the 2nd RUN cycle. State returns to IDLE with sum=0, carry=0, and no done for the following 10 cycles.
- SERIAL_ADDER_SUB_EN, WIDTH=4:
  - sub=1, A=5, B=3: sum=2, carry=1.
  - sub=1, A=3, B=5: sum=14, carry=0.
  - sub=0, A=3, B=5: sum=8, carry=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The optional sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             done;
   logic [1:0]       dbg_state;

   // Handshake: start is accepted on a rising edge where ready=1; done pulses
   // for one cycle when sum/carry have just been updated.
`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, A, B, sub, input ready, sum, carry, done, dbg_state);
   modport slave  (input start, A, B, sub, output ready, sum, carry, done, dbg_state);
`else
   modport master (output start, A, B, input ready, sum, carry, done, dbg_state);
   modport slave  (input start, A, B, output ready, sum, carry, done, dbg_state);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one half-adder pair plus a carry flop, WIDTH+1 clocks per result.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;

   logic sub_in;
   logic ha_p, ha_g, bit_s;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      ha_p    = a_q[0] ^ b_q[0];
      ha_g    = a_q[0] & b_q[0];
      bit_s   = ha_p ^ c_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               a_d     = bus.A;
               // Subtraction is A + ~B + 1: invert B and seed the carry.
               b_d     = sub_in ? ~bus.B : bus.B;
               c_d     = sub_in;
               cnt_d   = '0;
               res_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            c_d            = ha_g | (c_q & ha_p);
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            res_d          = res_q >> 1;
            res_d[WIDTH-1] = bit_s;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sum_d   = res_d;
               carry_d = c_d;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.carry     = carry_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=4 with hand-computed results.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse, then wait for done; n counts negedges after the accept edge.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb, input logic [W-1:0] exp_sum, input logic exp_c);
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = a;
      bus.B = b;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = sb;
`else
      if (sb) $display("note: sub requested without subtract build");
`endif
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 20);
      chk({tag, "_latency"}, n, 5);
      chk({tag, "_sum"}, bus.sum, exp_sum);
      chk({tag, "_carry"}, bus.carry, exp_c);
   endtask

   initial begin
      int n;
      int dones;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset then idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", bus.ready, 1);
         chk("idle_sum", bus.sum, 0);
         chk("idle_carry", bus.carry, 0);
         chk("idle_done", bus.done, 0);
      end

      run_op("add_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
      chk("done_ready", bus.ready, 1);
      @(negedge clk);
      chk("hold_done", bus.done, 0);
      chk("hold_sum", bus.sum, 8);
      chk("hold_state", bus.dbg_state, 0);

      run_op("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
      run_op("add_15_15", 4'd15, 4'd15, 1'b0, 4'd14, 1'b1);
      run_op("add_0_0", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);

      // start during RUN is ignored, then restart from the DONE cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 4'd2;
      bus.B = 4'd2;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      dones = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk("busy_ready", bus.ready, 0);
         if (n == 2) begin
            bus.start = 1'b1;
            bus.A = 4'd7;
            bus.B = 4'd7;
         end
         if (n == 3) bus.start = 1'b0;
      end while (!bus.done && n < 20);
      chk("busy_latency", n, 5);
      chk("busy_sum", bus.sum, 4);
      chk("busy_carry", bus.carry, 0);
      bus.start = 1'b1;
      bus.A = 4'd1;
      bus.B = 4'd1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.done) dones++;
      end while (!bus.done && n < 20);
      chk("b2b_latency", n, 5);
      chk("b2b_sum", bus.sum, 2);
      chk("b2b_dones", dones, 1);

      // reset on the second RUN cycle discards the operation
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = 4'd9;
      bus.B = 4'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("rst_dones", dones, 0);
      chk("rst_state", bus.dbg_state, 0);
      chk("rst_ready", bus.ready, 1);
      chk("rst_sum", bus.sum, 0);
      chk("rst_carry", bus.carry, 0);

`ifdef SERIAL_ADDER_SUB_EN
      run_op("sub_5_3", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1);
      run_op("sub_3_5", 4'd3, 4'd5, 1'b1, 4'd14, 1'b0);
      run_op("nosub_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
